// File: rtl/custom_bus_matrix_input_stage.sv
// ---------------------------------------------------------------------------
// custom_bus_matrix_input_stage
//
// Per-master input stage of the AHB bus matrix. Presents the master's address
// phase to the output-stage arbiter. When the output stage has not granted
// this port, the address-phase controls are captured into a holding register.
// The master is then stalled with wait states, and the held transfer is
// replayed once the output stage grants the port.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HSELS..HMASTLOCKS    address phase from the master side
//   HREADYS              bus-level HREADY as seen by the master
//   active_trans         output stage has this port in address phase
//   data_in_phase        output stage has this port in data phase
//   HREADYOUTM, HRESPM   slave response routed back through the output stage
//   HREADYOUTS, HRESPS   response to the master
//   req_port             arbitration request toward the output stage
//   HSELM..HMASTLOCKM    address phase presented to the output stage
// ---------------------------------------------------------------------------
module custom_bus_matrix_input_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int PROT_WIDTH = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [PROT_WIDTH-1:0] HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  input  logic                  active_trans,
  input  logic                  data_in_phase,
  input  logic                  HREADYOUTM,
  input  logic                  HRESPM,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  req_port,
  output logic                  HSELM,
  output logic [ADDR_WIDTH-1:0] HADDRM,
  output logic [1:0]            HTRANSM,
  output logic                  HWRITEM,
  output logic [2:0]            HSIZEM,
  output logic [2:0]            HBURSTM,
  output logic [PROT_WIDTH-1:0] HPROTM,
  output logic                  HMASTLOCKM
);

  logic                  pend_reg;
  logic                  pend_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [1:0]            trans_reg;
  logic                  write_reg;
  logic [2:0]            size_reg;
  logic [2:0]            burst_reg;
  logic [PROT_WIDTH-1:0] prot_reg;
  logic                  lock_reg;

  logic                  load;
  logic                  taken;
  logic [1:0]            trans_sel;

  // Master issues NONSEQ/SEQ and the bus is ready to accept it.
  assign load  = HSELS & HTRANSS[1] & HREADYS;
  // Output stage samples whatever is being presented this cycle.
  assign taken = active_trans & HREADYOUTM;

  always_comb begin
    pend_next = pend_reg;
    if (pend_reg) begin
      pend_next = ~taken;
    end else if (load) begin
      // load & taken passes straight through with no holding.
      pend_next = ~taken;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_reg <= 1'b0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  // Holding register is frozen while a transfer is pending, so a master that
  // misbehaves by changing its address phase during wait states cannot
  // corrupt the replay.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_reg  <= '0;
      trans_reg <= 2'b00;
      write_reg <= 1'b0;
      size_reg  <= 3'b000;
      burst_reg <= 3'b000;
      prot_reg  <= '0;
      lock_reg  <= 1'b0;
    end else if (load && !pend_reg) begin
      addr_reg  <= HADDRS;
      trans_reg <= HTRANSS;
      write_reg <= HWRITES;
      size_reg  <= HSIZES;
      burst_reg <= HBURSTS;
      prot_reg  <= HPROTS;
      lock_reg  <= HMASTLOCKS;
    end
  end

  // Output mux. The held path is presented unmodified (a held SEQ stays SEQ).
  always_comb begin
    if (pend_reg) begin
      HSELM      = 1'b1;
      HADDRM     = addr_reg;
      trans_sel  = trans_reg;
      HWRITEM    = write_reg;
      HSIZEM     = size_reg;
      HBURSTM    = burst_reg;
      HPROTM     = prot_reg;
      HMASTLOCKM = lock_reg;
    end else begin
      HSELM      = HSELS;
      HADDRM     = HADDRS;
      trans_sel  = HTRANSS;
      HWRITEM    = HWRITES;
      HSIZEM     = HSIZES;
      HBURSTM    = HBURSTS;
      HPROTM     = HPROTS;
      HMASTLOCKM = HMASTLOCKS;
    end
  end

  assign HTRANSM = HSELM ? trans_sel : 2'b00;

  // BUSY does not request; the arbiter keeps the port through HSELM instead.
  assign req_port = pend_reg | (HSELS & HTRANSS[1]);

  always_comb begin
    if (data_in_phase) begin
      HREADYOUTS = HREADYOUTM;
    end else if (pend_reg) begin
      HREADYOUTS = 1'b0;
    end else begin
      HREADYOUTS = 1'b1;
    end
  end

  assign HRESPS = data_in_phase ? HRESPM : 1'b0;

endmodule

// File: tb/tb_custom_bus_matrix_input_stage.sv
module tb_custom_bus_matrix_input_stage;

  localparam int AW = 32;
  localparam int PW = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSELS;
  logic [AW-1:0] HADDRS;
  logic [1:0]    HTRANSS;
  logic          HWRITES;
  logic [2:0]    HSIZES;
  logic [2:0]    HBURSTS;
  logic [PW-1:0] HPROTS;
  logic          HMASTLOCKS;
  logic          HREADYS;
  logic          active_trans;
  logic          data_in_phase;
  logic          HREADYOUTM;
  logic          HRESPM;
  logic          HREADYOUTS;
  logic          HRESPS;
  logic          req_port;
  logic          HSELM;
  logic [AW-1:0] HADDRM;
  logic [1:0]    HTRANSM;
  logic          HWRITEM;
  logic [2:0]    HSIZEM;
  logic [2:0]    HBURSTM;
  logic [PW-1:0] HPROTM;
  logic          HMASTLOCKM;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  custom_bus_matrix_input_stage #(.ADDR_WIDTH(AW), .PROT_WIDTH(PW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .active_trans(active_trans), .data_in_phase(data_in_phase),
    .HREADYOUTM(HREADYOUTM), .HRESPM(HRESPM), .HREADYOUTS(HREADYOUTS),
    .HRESPS(HRESPS), .req_port(req_port), .HSELM(HSELM), .HADDRM(HADDRM),
    .HTRANSM(HTRANSM), .HWRITEM(HWRITEM), .HSIZEM(HSIZEM), .HBURSTM(HBURSTM),
    .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM)
  );

  typedef struct packed {
    logic          sel;
    logic [1:0]    trans;
    logic [AW-1:0] addr;
    logic          hreadys;
    logic          act;
    logic          dip;
    logic          rdym;
    logic          respm;
    logic          exp_ready;
    logic          exp_resp;
    logic          exp_req;
    logic          exp_hselm;
    logic [1:0]    exp_trans;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic master_idle();
    HSELS = 1'b0; HADDRS = '0; HTRANSS = 2'b00; HWRITES = 1'b0;
    HSIZES = 3'b000; HBURSTS = 3'b000; HPROTS = '0; HMASTLOCKS = 1'b0;
    HREADYS = 1'b1; active_trans = 1'b0; data_in_phase = 1'b0;
    HREADYOUTM = 1'b1; HRESPM = 1'b0;
  endtask

  initial begin
    master_idle();
    HRESETn = 1'b0;
    #1;
    // Reset state
    check("rst_hreadyouts", 64'(HREADYOUTS), 64'd1);
    check("rst_hresps", 64'(HRESPS), 64'd0);
    check("rst_req", 64'(req_port), 64'd0);
    check("rst_hselm", 64'(HSELM), 64'd0);
    check("rst_htransm", 64'(HTRANSM), 64'd0);
    check("rst_haddrm", 64'(HADDRM), 64'd0);
    $display("reset: hreadyouts=%0d req=%0d htransm=%0d", HREADYOUTS, req_port, HTRANSM);
    step();
    step();
    HRESETn = 1'b1;
    step();

    // Single-cycle vectors; none of them leaves a transfer pending.
    //             sel trans addr          rdyS act dip rdyM respM | rdy resp req hsel trans addr
    vecs[0] = '{1'b1, 2'b10, 32'h2000_0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 32'h2000_0010};
    vecs[1] = '{1'b1, 2'b01, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_1234};
    vecs[2] = '{1'b0, 2'b10, 32'h5555_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h5555_0000};
    vecs[3] = '{1'b1, 2'b00, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0040};
    vecs[4] = '{1'b0, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0000};
    vecs[5] = '{1'b0, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0000_0000};
    vecs[6] = '{1'b1, 2'b11, 32'h2000_0014, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 32'h2000_0014};
    vecs[7] = '{1'b1, 2'b10, 32'h3000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 32'h3000_0000};
    vecs[8] = '{1'b0, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0000_0000};

    for (int i = 0; i < 9; i++) begin
      master_idle();
      HSELS = vecs[i].sel; HTRANSS = vecs[i].trans; HADDRS = vecs[i].addr;
      HREADYS = vecs[i].hreadys; active_trans = vecs[i].act;
      data_in_phase = vecs[i].dip; HREADYOUTM = vecs[i].rdym; HRESPM = vecs[i].respm;
      #1;
      check($sformatf("v%0d_hreadyouts", i), 64'(HREADYOUTS), 64'(vecs[i].exp_ready));
      check($sformatf("v%0d_hresps", i), 64'(HRESPS), 64'(vecs[i].exp_resp));
      check($sformatf("v%0d_req", i), 64'(req_port), 64'(vecs[i].exp_req));
      check($sformatf("v%0d_hselm", i), 64'(HSELM), 64'(vecs[i].exp_hselm));
      check($sformatf("v%0d_htransm", i), 64'(HTRANSM), 64'(vecs[i].exp_trans));
      check($sformatf("v%0d_haddrm", i), 64'(HADDRM), 64'(vecs[i].exp_addr));
      $display("vec %0d: sel=%0d trans=%0d addr=0x%08h -> rdy=%0d resp=%0d req=%0d hselm=%0d htransm=%0d haddrm=0x%08h",
               i, HSELS, HTRANSS, HADDRS, HREADYOUTS, HRESPS, req_port, HSELM, HTRANSM, HADDRM);
      step();
      // None of the vectors may have left the port stalled.
      master_idle();
      #1;
      check($sformatf("v%0d_no_pend", i), 64'(HREADYOUTS), 64'd1);
    end

    // Held transfer: NONSEQ write, no grant for 3 cycles, then granted.
    master_idle();
    HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h4000_0000; HWRITES = 1'b1;
    HSIZES = 3'b010; HBURSTS = 3'b001; HPROTS = 4'h3; HMASTLOCKS = 1'b1;
    active_trans = 1'b0;
    #1;
    check("hold_pre_req", 64'(req_port), 64'd1);
    check("hold_pre_ready", 64'(HREADYOUTS), 64'd1);
    step();
    // Master stalls and (illegally) changes its address phase.
    HREADYS = 1'b0; HADDRS = 32'h0; HWRITES = 1'b0; HMASTLOCKS = 1'b0; HSIZES = 3'b000;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_ready", 64'(HREADYOUTS), 64'd0);
      check("hold_addr", 64'(HADDRM), 64'h4000_0000);
      check("hold_write", 64'(HWRITEM), 64'd1);
      check("hold_size", 64'(HSIZEM), 64'd2);
      check("hold_lock", 64'(HMASTLOCKM), 64'd1);
      check("hold_req", 64'(req_port), 64'd1);
      check("hold_trans", 64'(HTRANSM), 64'd2);
      $display("hold cycle %0d: rdy=%0d haddrm=0x%08h hwritem=%0d lock=%0d req=%0d",
               k, HREADYOUTS, HADDRM, HWRITEM, HMASTLOCKM, req_port);
      step();
    end
    active_trans = 1'b1; HREADYOUTM = 1'b1;
    #1;
    check("grant_ready", 64'(HREADYOUTS), 64'd0);
    check("grant_addr", 64'(HADDRM), 64'h4000_0000);
    step();
    master_idle();
    #1;
    check("after_take_ready", 64'(HREADYOUTS), 64'd1);
    check("after_take_req", 64'(req_port), 64'd0);
    check("after_take_trans", 64'(HTRANSM), 64'd0);
    $display("held transfer taken: rdy=%0d req=%0d", HREADYOUTS, req_port);
    step();

    // Data-phase wait states then a two-cycle ERROR response.
    begin
      logic [2:0] rdy_seq;
      logic [1:0] err_rdy;
      rdy_seq = 3'b100;
      err_rdy = 2'b10;
      master_idle();
      data_in_phase = 1'b1;
      for (int k = 0; k < 3; k++) begin
        HREADYOUTM = rdy_seq[k];
        #1;
        check("wait_ready", 64'(HREADYOUTS), 64'(rdy_seq[k]));
        check("wait_resp", 64'(HRESPS), 64'd0);
        $display("wait %0d: hreadyoutm=%0d -> hreadyouts=%0d", k, HREADYOUTM, HREADYOUTS);
        step();
      end
      HRESPM = 1'b1;
      for (int k = 0; k < 2; k++) begin
        HREADYOUTM = err_rdy[k];
        #1;
        check("err_resp", 64'(HRESPS), 64'd1);
        check("err_ready", 64'(HREADYOUTS), 64'(err_rdy[k]));
        $display("error %0d: hresps=%0d hreadyouts=%0d", k, HRESPS, HREADYOUTS);
        step();
      end
    end

    // Reset in the middle of a pending transfer discards it.
    master_idle();
    HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h6000_0000;
    step();
    HREADYS = 1'b0;
    #1;
    check("rstp_pending", 64'(HREADYOUTS), 64'd0);
    #2;
    master_idle();
    HRESETn = 1'b0;
    #1;
    check("rstp_ready", 64'(HREADYOUTS), 64'd1);
    check("rstp_req", 64'(req_port), 64'd0);
    check("rstp_trans", 64'(HTRANSM), 64'd0);
    $display("reset mid-pend: rdy=%0d req=%0d htransm=%0d", HREADYOUTS, req_port, HTRANSM);
    step();
    HRESETn = 1'b1;
    active_trans = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("no_replay_hselm", 64'(HSELM), 64'd0);
      check("no_replay_req", 64'(req_port), 64'd0);
      check("no_replay_addr", 64'(HADDRM), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/custom_bus_matrix_input_stage.md
Name: custom_bus_matrix_input_stage

Overview:
- Per-master input stage of the custom AHB bus matrix, the initiator-facing end of the output-stage arbiters.
- Accepts the master's address phase and raises a request toward the output stage.
- If the target output stage has not granted this port, it latches the address-phase controls in a holding register, inserts wait states to the master, and replays the held transfer once granted.
- One instance per master port; its request output feeds the arbiter's req_portN input.

Parameters:
ADDR_WIDTH, 32, width of HADDRS/HADDRM
PROT_WIDTH, 4, width of HPROTS/HPROTM

Ports:
HCLK  in  1  AHB system clock, single clock domain
HRESETn  in  1  asynchronous active-low reset
HSELS  in  1  slave select from master-side decoder
HADDRS  in  ADDR_WIDTH  master address
HTRANSS  in  2  master transfer type
HWRITES  in  1  master write flag
HSIZES  in  3  master transfer size
HBURSTS  in  3  master burst type
HPROTS  in  PROT_WIDTH  master protection
HMASTLOCKS  in  1  master locked transfer
HREADYS  in  1  HREADY as seen by the master (bus-level)
active_trans  in  1  output stage has this port in address phase (granted and no_port low)
data_in_phase  in  1  output stage has this port in data phase
HREADYOUTM  in  1  slave HREADYOUT routed back via output stage
HRESPM  in  1  slave HRESP routed back via output stage
HREADYOUTS  out  1  ready to master
HRESPS  out  1  response to master
req_port  out  1  arbitration request to output stage
HSELM  out  1  select presented to output stage
HADDRM  out  ADDR_WIDTH  address presented
HTRANSM  out  2  transfer type presented
HWRITEM  out  1  write flag presented
HSIZEM  out  3  size presented
HBURSTM  out  3  burst presented
HPROTM  out  PROT_WIDTH  protection presented
HMASTLOCKM  out  1  lock presented

Behaviour:
- Reset (async, HRESETn low): pend_reg=0; holding register all zeros. Outputs: HREADYOUTS=1, HRESPS=0, req_port=0, HSELM=0, HTRANSM=IDLE(00), all other M outputs 0.
- Definitions:
  - load = HSELS & HTRANSS[1] & HREADYS (NONSEQ/SEQ accepted from the master).
  - taken = active_trans & HREADYOUTM (output stage samples the presented address this cycle).
- Holding register: on load, capture HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS on the next HCLK edge. It is not updated while pend_reg=1.
- pend_reg next state:
  - load & ~taken -> 1
  - pend_reg & taken -> 0
  - load & taken -> 0 (pass-through, zero latency)
  - otherwise hold.
- Output mux:
  - pend_reg=1: M outputs = holding register, HSELM=1.
  - pend_reg=0: M outputs = live S inputs, HSELM=HSELS.
  - HTRANSM is forced to IDLE when HSELM=0.
- req_port = pend_reg | (HSELS & HTRANSS[1]). A BUSY transfer (HTRANSS=01) with HSELS high does not request. The arbiter keeps such a port via HSELM.
- HREADYOUTS priority:
  1. data_in_phase -> HREADYOUTM
  2. pend_reg -> 0
  3. else 1
- HRESPS = data_in_phase ? HRESPM : 0. Two-cycle ERROR passes through unmodified.
- Master signals arriving while pend_reg=1 are not sampled; the master must hold them stable, since HREADYS is low.
- Held SEQ replayed after a regrant is presented unmodified. The output-stage burst counter resets on deselect and treats it accordingly.
- Lock: a held transfer with HMASTLOCKS=1 presents HMASTLOCKM=1 until taken.
- Simultaneous events:
  - load in the same cycle pend_reg clears is impossible, because HREADYS is low while pending.
  - Reset mid-pend discards the held transfer; no replay afterwards.
- Latency: pass-through 0 cycles. A held transfer adds 1 wait state minimum, plus one per cycle without a grant.

Test Plan:
- Reset: HRESETn=0 mid-pend -> pend_reg=0, HREADYOUTS=1, HTRANSM=00, req_port=0 immediately; no replay after release.
- Pass-through: HSELS=1, HTRANSS=10, HADDRS=0x2000_0010, active_trans=1, HREADYOUTM=1 -> HADDRM=0x2000_0010 same cycle, pend_reg stays 0, HREADYOUTS=1.
- Held transfer: NONSEQ write to 0x4000_0000 accepted with active_trans=0 for 3 cycles -> HREADYOUTS=0 for 3 cycles, HADDRM=0x4000_0000, HWRITEM=1, req_port=1; active_trans rises -> pend_reg clears next edge.
- Wait/response pass-through: data_in_phase=1, HREADYOUTM=0,0,1 -> HREADYOUTS=0,0,1. Error with HRESPM=1 for 2 cycles (HREADYOUTM 0 then 1) -> HRESPS=1,1 and HREADYOUTS=0,1.
- Master change while pending: HADDRS changed to 0x0 during pend -> HADDRM still shows the held address until taken.
- BUSY/IDLE: HTRANSS=01 with HSELS=1 -> req_port=0 and no load. HSELS=0 -> HSELM=0, HTRANSM=00.
